bout_referee: RTL and testbench

//  Match-level scheduler for the per-player action FSM.
//  - Paces the action FSM once per video frame via its sync strobe and receives its per-frame result.
//  - Tallies touches for both fencers and pulses a reset into the action FSM between points.
//  - Runs the start countdown, the post-point pause and the match-over condition.
//  - Sits between the frame/vsync logic, the action FSM and the display/score overlay.

---
 rtl/bout_referee_pkg.sv | 34 +++
 rtl/bout_referee_frame_timer.sv | 34 +++
 rtl/bout_referee.sv | 159 +++++++++++++++
 tb/tb_bout_referee.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bout_referee_pkg.sv
// Shared types and constants for the bout referee: state and winner encodings,
// counter widths and the countdown seconds helper.
package bout_referee_pkg;

  localparam int unsigned POINT_W = 4;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StCountdown  = 3'd1,
    StFight      = 3'd2,
    StPointPause = 3'd3,
    StMatchOver  = 3'd4
  } referee_state_t;

  typedef enum logic [1:0] {
    WinNone     = 2'b00,
    WinPlayer   = 2'b01,
    WinOpponent = 2'b10
  } winner_t;

  // Whole seconds still to show, rounded up: counts the second boundaries still ahead.
  function automatic logic [1:0] secs_left(input logic [TIMER_W-1:0] frames,
                                           input int unsigned fps,
                                           input int unsigned secs);
    logic [1:0] n;
    n = 2'd0;
    for (int unsigned k = 0; k < secs; k++) begin
      if (32'(frames) > k * fps) n = n + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bout_referee_frame_timer.sv
// Loadable frame down-counter shared by the countdown and the post-point pause.
module bout_referee_frame_timer
  import bout_referee_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  // Fires on the frame that takes the count to zero.
  assign done_o  = tick_i && (count_q <= TIMER_W'(1));

endmodule

// File: rtl/bout_referee.sv
// Match-level scheduler: paces the action FSM per frame, tallies touches and
// runs countdown, post-point pause and match-over.
module bout_referee
  import bout_referee_pkg::*;
#(
  parameter int unsigned FPS           = 60,
  parameter int unsigned COUNTDOWN_SEC = 3,
  parameter int unsigned PAUSE_FRAMES  = 90,
  parameter int unsigned POINTS_TO_WIN = 5,
  parameter int unsigned RESP_TIMEOUT  = 32
) (
  input  logic               clk_pixel_in,
  input  logic               rst_in,
  input  logic               frame_start_in,
  input  logic               start_in,
  input  logic               fsm_valid_in,
  input  logic               player_scored_in,
  input  logic               opponent_scored_in,
  output logic               sync_valid_out,
  output logic               fsm_rst_out,
  output logic [POINT_W-1:0] player_points_out,
  output logic [POINT_W-1:0] opponent_points_out,
  output logic [1:0]         countdown_out,
  output logic [2:0]         state_out,
  output logic [1:0]         winner_out,
  output logic               timeout_err_out
);

  localparam logic [TIMER_W-1:0] CountdownLoad = TIMER_W'(COUNTDOWN_SEC * FPS);
  localparam logic [TIMER_W-1:0] PauseLoad     = TIMER_W'(PAUSE_FRAMES);
  localparam logic [POINT_W-1:0] WinPoints     = POINT_W'(POINTS_TO_WIN);
  localparam int unsigned        WaitW         = $clog2(RESP_TIMEOUT);
  localparam logic [WaitW-1:0]   WaitLast      = WaitW'(RESP_TIMEOUT - 1);

  referee_state_t     state_d, state_q;
  winner_t            winner_d, winner_q;
  logic [POINT_W-1:0] player_pts_d, player_pts_q, opp_pts_d, opp_pts_q;
  logic               err_d, err_q, sync_d, sync_q, fsm_rst_d, fsm_rst_q;
  logic               waiting_d, waiting_q;
  logic [WaitW-1:0]   wait_cnt_d, wait_cnt_q;
  logic               timer_load, timer_done;
  logic [TIMER_W-1:0] timer_val, timer_count;

  bout_referee_frame_timer u_frame_timer (
    .clk_i      (clk_pixel_in),
    .rst_i      (rst_in),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tick_i     (frame_start_in),
    .count_o    (timer_count),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    player_pts_d = player_pts_q;
    opp_pts_d    = opp_pts_q;
    err_d        = err_q;
    sync_d       = 1'b0;
    fsm_rst_d    = 1'b0;
    waiting_d    = waiting_q;
    wait_cnt_d   = wait_cnt_q;
    timer_load   = 1'b0;
    timer_val    = CountdownLoad;
    unique case (state_q)
      StIdle, StMatchOver: begin
        if (frame_start_in && start_in) begin
          state_d      = StCountdown;
          winner_d     = WinNone;
          player_pts_d = '0;
          opp_pts_d    = '0;
          err_d        = 1'b0;
          fsm_rst_d    = 1'b1;
          timer_load   = 1'b1;
        end
      end
      StCountdown: begin
        if (timer_done) state_d = StFight;
      end
      StFight: begin
        // Frames arriving while a response is outstanding are dropped.
        if (waiting_q) begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
          if (fsm_valid_in) begin
            waiting_d = 1'b0;
            if (player_scored_in || opponent_scored_in) begin
              state_d    = StPointPause;
              timer_load = 1'b1;
              timer_val  = PauseLoad;
            end
            if (player_scored_in && !opponent_scored_in && (player_pts_q != WinPoints)) begin
              player_pts_d = player_pts_q + POINT_W'(1);
            end
            if (opponent_scored_in && !player_scored_in && (opp_pts_q != WinPoints)) begin
              opp_pts_d = opp_pts_q + POINT_W'(1);
            end
          end else if (wait_cnt_q == WaitLast) begin
            waiting_d = 1'b0;
            err_d     = 1'b1;
            fsm_rst_d = 1'b1;
          end
        end else if (frame_start_in) begin
          sync_d     = 1'b1;
          waiting_d  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      StPointPause: begin
        if (timer_done) begin
          if ((player_pts_q == WinPoints) || (opp_pts_q == WinPoints)) begin
            state_d  = StMatchOver;
            winner_d = (player_pts_q == WinPoints) ? WinPlayer : WinOpponent;
          end else begin
            state_d    = StCountdown;
            fsm_rst_d  = 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      winner_q     <= WinNone;
      player_pts_q <= '0;
      opp_pts_q    <= '0;
      err_q        <= 1'b0;
      sync_q       <= 1'b0;
      fsm_rst_q    <= 1'b0;
      waiting_q    <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      player_pts_q <= player_pts_d;
      opp_pts_q    <= opp_pts_d;
      err_q        <= err_d;
      sync_q       <= sync_d;
      fsm_rst_q    <= fsm_rst_d;
      waiting_q    <= waiting_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign sync_valid_out      = sync_q;
  assign fsm_rst_out         = fsm_rst_q;
  assign player_points_out   = player_pts_q;
  assign opponent_points_out = opp_pts_q;
  assign state_out           = state_q;
  assign winner_out          = winner_q;
  assign timeout_err_out     = err_q;
  assign countdown_out       = (state_q == StCountdown) ?
                               secs_left(timer_count, FPS, COUNTDOWN_SEC) : 2'd0;

endmodule

// File: tb/tb_bout_referee.sv
// Self-checking bench for bout_referee: directed match flow with randomized
// response timing, stray inputs and point outcomes against a frame-level model.
module tb_bout_referee;

  // Model state numbering follows the referee state list order.
  localparam int MIdle = 0, MCount = 1, MFight = 2, MPause = 3, MOver = 4;
  localparam int Win = 5, CdFrames = 180, PauseFrames = 90, Fps = 60;

  logic       clk = 1'b0;
  logic       rst_in, frame_start_in, start_in, fsm_valid_in;
  logic       player_scored_in, opponent_scored_in;
  logic       sync_valid_out, fsm_rst_out, timeout_err_out;
  logic [3:0] player_points_out, opponent_points_out;
  logic [1:0] countdown_out, winner_out;
  logic [2:0] state_out;

  int checks = 0, errors = 0;
  int m_state, m_left, m_pp, m_op, m_win, m_err;
  bit start_lvl;

  always #5 clk = ~clk;

  bout_referee dut (
    .clk_pixel_in        (clk),
    .rst_in              (rst_in),
    .frame_start_in      (frame_start_in),
    .start_in            (start_in),
    .fsm_valid_in        (fsm_valid_in),
    .player_scored_in    (player_scored_in),
    .opponent_scored_in  (opponent_scored_in),
    .sync_valid_out      (sync_valid_out),
    .fsm_rst_out         (fsm_rst_out),
    .player_points_out   (player_points_out),
    .opponent_points_out (opponent_points_out),
    .countdown_out       (countdown_out),
    .state_out           (state_out),
    .winner_out          (winner_out),
    .timeout_err_out     (timeout_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state_out), m_state);
    chk({tag, ".countdown"}, 32'(countdown_out), (m_state == MCount) ? (m_left + Fps - 1) / Fps : 0);
    chk({tag, ".player_pts"}, 32'(player_points_out), m_pp);
    chk({tag, ".opp_pts"}, 32'(opponent_points_out), m_op);
    chk({tag, ".winner"}, 32'(winner_out), m_win);
    chk({tag, ".timeout_err"}, 32'(timeout_err_out), m_err);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    m_state = MIdle; m_left = 0; m_pp = 0; m_op = 0; m_win = 0; m_err = 0;
    chk("reset.sync", 32'(sync_valid_out), 0);
    chk("reset.fsm_rst", 32'(fsm_rst_out), 0);
    check_all("reset");
  endtask

  // One frame outside FIGHT: two cycles long, optional stray response in the gap.
  task automatic frame_nf(input bit stray);
    int exp_rst;
    exp_rst = 0;
    frame_start_in = 1'b1;
    start_in = (m_state == MIdle || m_state == MOver) ? start_lvl : 1'($urandom_range(0, 1));
    case (m_state)
      MIdle, MOver: if (start_in) begin
        m_state = MCount; m_left = CdFrames; m_pp = 0; m_op = 0; m_win = 0; m_err = 0;
        exp_rst = 1;
      end
      MCount: begin
        m_left--;
        if (m_left == 0) m_state = MFight;
      end
      MPause: begin
        m_left--;
        if (m_left == 0) begin
          if (m_pp == Win || m_op == Win) begin
            m_state = MOver;
            m_win = (m_pp == Win) ? 1 : 2;
          end else begin
            m_state = MCount; m_left = CdFrames; exp_rst = 1;
          end
        end
      end
      default: ;
    endcase
    @(negedge clk);
    frame_start_in = 1'b0;
    chk("frame.sync", 32'(sync_valid_out), 0);
    chk("frame.fsm_rst", 32'(fsm_rst_out), exp_rst);
    check_all("frame");
    if (stray) begin
      fsm_valid_in = 1'b1;
      player_scored_in = 1'($urandom_range(0, 1));
      opponent_scored_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    fsm_valid_in = 1'b0; player_scored_in = 1'b0; opponent_scored_in = 1'b0;
    chk("gap.fsm_rst", 32'(fsm_rst_out), 0);
    check_all("gap");
  endtask

  task automatic run_to_fight();
    while (m_state == MCount || m_state == MPause) frame_nf(1'($urandom_range(0, 1)));
  endtask

  // kind: 0 no response (timeout), 1 neither, 2 player, 3 opponent, 4 double touch.
  task automatic fight_frame(input int kind, input int d);
    bit drop;
    int last;
    drop = (kind == 0) || (d >= 3);
    last = (kind == 0) ? 33 : 2 + d;
    frame_start_in = 1'b1;
    start_in = 1'($urandom_range(0, 1));
    @(negedge clk);
    frame_start_in = 1'b0;
    chk("fight.sync", 32'(sync_valid_out), 1);
    chk("fight.fsm_rst", 32'(fsm_rst_out), 0);
    for (int k = 1; k <= last; k++) begin
      if (k == 2 && drop) frame_start_in = 1'b1;
      if (k == 3 && drop) begin
        frame_start_in = 1'b0;
        chk("dropped_frame.sync", 32'(sync_valid_out), 0);
      end
      if (kind != 0 && k == 1 + d) begin
        fsm_valid_in = 1'b1;
        player_scored_in = (kind == 2 || kind == 4);
        opponent_scored_in = (kind == 3 || kind == 4);
      end
      if (kind != 0 && k == 2 + d) begin
        fsm_valid_in = 1'b0; player_scored_in = 1'b0; opponent_scored_in = 1'b0;
        if (kind >= 2) begin m_state = MPause; m_left = PauseFrames; end
        if (kind == 2 && m_pp < Win) m_pp++;
        if (kind == 3 && m_op < Win) m_op++;
        chk("resp.fsm_rst", 32'(fsm_rst_out), 0);
        check_all("resp");
      end
      if (kind == 0 && k == 33) begin
        m_err = 1;
        chk("timeout.fsm_rst", 32'(fsm_rst_out), 1);
        chk("timeout.sync", 32'(sync_valid_out), 0);
        check_all("timeout");
      end
      if (k < last) @(negedge clk);
    end
    // Response outside the wait window must be ignored.
    fsm_valid_in = 1'b1; player_scored_in = 1'b1; opponent_scored_in = 1'b0;
    @(negedge clk);
    fsm_valid_in = 1'b0; player_scored_in = 1'b0;
    chk("stray.fsm_rst", 32'(fsm_rst_out), 0);
    check_all("stray");
    if (kind == 0) repeat (2) @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, r, guard;
    rst_in = 1'b1; frame_start_in = 1'b0; start_in = 1'b0; fsm_valid_in = 1'b0;
    player_scored_in = 1'b0; opponent_scored_in = 1'b0; start_lvl = 1'b0;
    @(negedge clk);
    do_reset();

    repeat (3) frame_nf(1'b1);              // idle without start: nothing happens
    start_lvl = 1'b1;
    frame_nf(1'b0);                         // start: reset pulse, countdown begins
    run_to_fight();

    fight_frame(1, $urandom_range(0, 31));  // no touch: stays in fight
    fight_frame(2, 2);                      // player touch
    run_to_fight();
    fight_frame(4, $urandom_range(0, 31));  // double touch
    run_to_fight();
    fight_frame(0, 0);                      // response withheld
    fight_frame(1, 31);                     // last accepted cycle
    fight_frame(1, 0);

    repeat (5) begin                        // opponent wins the bout
      fight_frame(3, $urandom_range(0, 31));
      run_to_fight();
    end
    start_lvl = 1'b0;
    repeat (4) frame_nf(1'b1);              // frozen after match over
    start_lvl = 1'b1;
    frame_nf(1'b0);                         // restart at 0-0
    run_to_fight();

    guard = 0;
    while (!(m_pp == 3 && m_op == 2) && guard < 80) begin
      guard++;
      r = $urandom_range(0, 5);
      kind = (r == 5) ? 1 : r;
      if (kind == 2 && m_pp >= 3) kind = 1;
      if (kind == 3 && m_op >= 2) kind = 1;
      fight_frame(kind, $urandom_range(0, 31));
      run_to_fight();
    end
    chk("score_3_2.player", 32'(player_points_out), 3);
    chk("score_3_2.opponent", 32'(opponent_points_out), 2);

    do_reset();                             // abort mid-fight
    start_lvl = 1'b0;
    repeat (3) frame_nf(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
